imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 32 +++
 rtl/imem_responder.sv | 133 +++++++++++++
 tb/tb_imem_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response and program-load bus for imem_responder
//
// Signals:
//   req_valid/req_addr/req_ready : fetch request handshake (64-bit byte address)
//   flush                        : cancel any pending fetch
//   rsp_valid/rsp_data/rsp_err   : fetch response (32-bit word, fault flag)
//   rsp_ready                    : consumer takes the response
//   wr_en/wr_addr/wr_data        : program-load write port
// Modports: master = fetch unit / loader side, slave = instruction memory side.
interface imem_responder_if;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory fetch responder
//
// Parameters:
//   DEPTH     : number of 32-bit words stored
//   LATENCY   : cycles from request acceptance to rsp_valid (1..15)
//   BASE_ADDR : byte address of word 0
// Ports:
//   CLK : clock, all state changes on the rising edge
//   RST : synchronous active-high reset (memory contents are kept)
//   bus : imem_responder_if.slave - fetch request/response, flush, program-load write
module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic           CLK,
    input  logic           RST,
    imem_responder_if.slave bus
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [63:0] addr_q;
    logic        capture;
    logic        load_rsp;
    logic        accept;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH];

    logic [63:0]      f_addr, f_off, w_off;
    logic             f_err, w_err;
    logic [IDX_W-1:0] f_idx, w_idx;

    // With LATENCY 1 the RESP state is entered on the accepting edge itself,
    // so the read must use the live request address rather than the captured one.
    assign f_addr = (state == IDLE) ? bus.req_addr : addr_q;

    // Full 64-bit arithmetic: an address below BASE_ADDR is caught by the
    // explicit compare, never by a wrapped offset.
    assign f_off = f_addr - BASE_ADDR;
    assign f_err = (f_addr[1:0] != 2'b00) || (f_addr < BASE_ADDR) || ((f_off >> 2) >= DEPTH_W);
    assign f_idx = f_off[IDX_W+1:2];

    assign w_off = bus.wr_addr - BASE_ADDR;
    assign w_err = (bus.wr_addr[1:0] != 2'b00) || (bus.wr_addr < BASE_ADDR) || ((w_off >> 2) >= DEPTH_W);
    assign w_idx = w_off[IDX_W+1:2];

    assign bus.req_ready = (state == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        capture  = 1'b0;
        load_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_n  = RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_n  = RESP;
                    load_rsp = 1'b1;
                    cnt_n    = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                // Flush and handshake both end the response; flush simply
                // means the word is treated as dropped.
                if (bus.flush || bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 64'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                addr_q <= bus.req_addr;
            end
            // Reads the pre-edge array contents, so a same-edge write to the
            // same word returns the old value.
            if (load_rsp) begin
                rsp_err_q  <= f_err;
                rsp_data_q <= f_err ? 32'h0 : mem[f_idx];
            end
        end
    end

    // Program-load port; deliberately outside reset so RST keeps the image.
    always_ff @(posedge CLK) begin
        if (bus.wr_en && !w_err) begin
            mem[w_idx] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard testbench for imem_responder (LATENCY 2 and LATENCY 1 instances)
module tb_imem_responder;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        req_valid [2];
    logic [63:0] req_addr  [2];
    logic        flush     [2];
    logic        rsp_ready [2];
    logic        wr_en     [2];
    logic [63:0] wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];

    exp_t exp_q [2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/none required event", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : 1;
        imem_responder_if bus ();

        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.flush     = flush[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign bus.wr_en     = wr_en[g];
        assign bus.wr_addr   = wr_addr[g];
        assign bus.wr_data   = wr_data[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_data[g]   = bus.rsp_data;
        assign rsp_err[g]    = bus.rsp_err;

        imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(64'h0)) u_dut (
            .CLK(clk),
            .RST(rst),
            .bus(bus)
        );

        int          acc_cyc = 0;
        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic [31:0] held_d = 32'h0;
        logic        held_e = 1'b0;
        exp_t        x;

        always @(negedge clk) begin
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
                if (rsp_valid[g]) begin
                    check($sformatf("dut%0d_req_ready_in_resp", g), 64'(req_ready[g]), 64'd0);
                    if (!prev_valid) begin
                        if (exp_q[g].size() == 0) begin
                            fail_now($sformatf("dut%0d_unexpected_rsp", g));
                        end else begin
                            x = exp_q[g].pop_front();
                            check($sformatf("dut%0d_rsp_data", g), 64'(rsp_data[g]), 64'(x.data));
                            check($sformatf("dut%0d_rsp_err", g), 64'(rsp_err[g]), 64'(x.err));
                            check($sformatf("dut%0d_latency", g), 64'(cyc - acc_cyc), 64'(LAT));
                        end
                    end else if (!prev_ready) begin
                        check($sformatf("dut%0d_hold_data", g), 64'(rsp_data[g]), 64'(held_d));
                        check($sformatf("dut%0d_hold_err", g), 64'(rsp_err[g]), 64'(held_e));
                    end
                end
                prev_valid = rsp_valid[g];
                prev_ready = rsp_ready[g];
                held_d     = rsp_data[g];
                held_e     = rsp_err[g];
            end
        end
    end

    // All tasks start and end at posedge+1 so input changes never race the negedge monitor.
    task automatic wr(input int w, input logic [63:0] a, input logic [31:0] d);
        wr_en[w]   = 1'b1;
        wr_addr[w] = a;
        wr_data[w] = d;
        @(posedge clk);
        #1;
        wr_en[w] = 1'b0;
    endtask

    task automatic issue(input int w, input logic [63:0] a);
        bit ok;
        ok = 1'b0;
        req_valid[w] = 1'b1;
        req_addr[w]  = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[w];
        end
        if (!ok) fail_now($sformatf("dut%0d_accept_timeout", w));
        @(posedge clk);
        #1;
        req_valid[w] = 1'b0;
    endtask

    task automatic wait_rsp(input int w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid[w];
        end
        if (!ok) fail_now($sformatf("dut%0d_rsp_timeout", w));
        @(posedge clk);
        #1;
    endtask

    task automatic finish_rsp(input int w, input int stall);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        rsp_ready[w] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[w] = 1'b0;
        @(negedge clk);
        check($sformatf("dut%0d_ready_after_hs", w), 64'(req_ready[w]), 64'd1);
        check($sformatf("dut%0d_valid_after_hs", w), 64'(rsp_valid[w]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int w, input logic [63:0] a, input logic [31:0] d, input logic e, input int stall);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q[w].push_back(x);
        issue(w, a);
        wait_rsp(w);
        finish_rsp(w, stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = 64'h0;
            flush[i]     = 1'b0;
            rsp_ready[i] = 1'b0;
            wr_en[i]     = 1'b0;
            wr_addr[i]   = 64'h0;
            wr_data[i]   = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready[0]), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("reset_rsp_data", 64'(rsp_data[0]), 64'd0);
        check("reset_rsp_err", 64'(rsp_err[0]), 64'd0);
        @(posedge clk);
        #1;

        // Program load, including discarded out-of-range and misaligned writes
        wr(0, 64'h0, 32'h0000_0013);
        wr(0, 64'h4, 32'h1111_1111);
        wr(0, 64'h8, 32'h0050_0093);
        wr(0, 64'hC, 32'hDEAD_BEEF);
        wr(0, 64'd252, 32'hCAFE_F00D);
        wr(0, 64'd256, 32'h1234_5678);
        wr(0, 64'h5, 32'h5555_5555);

        // Basic fetch, backpressure, boundaries and faults
        fetch(0, 64'h8, 32'h0050_0093, 1'b0, 0);
        fetch(0, 64'hC, 32'hDEAD_BEEF, 1'b0, 5);
        fetch(0, 64'h6, 32'h0, 1'b1, 0);
        fetch(0, 64'd256, 32'h0, 1'b1, 0);
        fetch(0, 64'd252, 32'hCAFE_F00D, 1'b0, 0);
        fetch(0, 64'h4, 32'h1111_1111, 1'b0, 2);
        fetch(0, 64'h1_0000_0008, 32'h0, 1'b1, 0);
        fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b1, 1);

        // Flush in IDLE blocks acceptance
        flush[0] = 1'b1;
        @(negedge clk);
        check("flush_idle_req_ready", 64'(req_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        flush[0] = 1'b0;

        // Flush one cycle after acceptance: fetch cancelled, no response
        issue(0, 64'h8);
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        @(negedge clk);
        check("ready_after_flush", 64'(req_ready[0]), 64'd1);
        check("no_rsp_after_flush", 64'(rsp_valid[0]), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_flush", 64'(rsp_valid[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        fetch(0, 64'h0, 32'h0000_0013, 1'b0, 0);

        // Flush in RESP together with rsp_ready: response dropped, FSM back to IDLE
        x.data = 32'h0050_0093;
        x.err  = 1'b0;
        exp_q[0].push_back(x);
        issue(0, 64'h8);
        wait_rsp(0);
        flush[0]     = 1'b1;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0]     = 1'b0;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("flush_resp_valid", 64'(rsp_valid[0]), 64'd0);
        check("flush_resp_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;

        // Reset while in RESP
        x.data = 32'hDEAD_BEEF;
        x.err  = 1'b0;
        exp_q[0].push_back(x);
        issue(0, 64'hC);
        wait_rsp(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_resp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_resp_data", 64'(rsp_data[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        fetch(0, 64'h8, 32'h0050_0093, 1'b0, 0);

        // LATENCY 1 instance: write/read collision on the edge entering RESP
        wr(1, 64'h0, 32'h0000_0013);
        x.data = 32'h0000_0013;
        x.err  = 1'b0;
        exp_q[1].push_back(x);
        req_valid[1] = 1'b1;
        req_addr[1]  = 64'h0;
        wr_en[1]     = 1'b1;
        wr_addr[1]   = 64'h0;
        wr_data[1]   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("collide_req_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wr_en[1]     = 1'b0;
        wait_rsp(1);
        finish_rsp(1, 0);
        fetch(1, 64'h0, 32'hFFFF_FFFF, 1'b0, 0);
        fetch(1, 64'h2, 32'h0, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("dut0_queue_empty", 64'(exp_q[0].size()), 64'd0);
        check("dut1_queue_empty", 64'(exp_q[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
